// File: rtl/delay_timer_pkg.sv
// rtl/delay_timer_pkg.sv - register map, bit indices and FSM types for the delay timer
package delay_timer_pkg;

   // Word register indices (byte address bits [4:2])
   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_LOAD     = 3'd1;
   localparam logic [2:0] REG_PRESCALE = 3'd2;
   localparam logic [2:0] REG_SCRATCH  = 3'd3;
   localparam logic [2:0] REG_STATUS   = 3'd4;
   localparam logic [2:0] REG_COUNT    = 3'd5;

   // CTRL bits
   localparam int CTRL_EN     = 0;
   localparam int CTRL_RELOAD = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bits
   localparam int STATUS_DONE    = 0;
   localparam int STATUS_RUNNING = 1;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_RESP} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ACCEPT, RD_DATA} rd_state_t;

   // Merge new_val into old_val on the bytes enabled by strb
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/delay_timer_core.sv
// rtl/delay_timer_core.sv - prescaler, down-counter and RUNNING/DONE flags
//  clk, rst_n          : clock, asynchronous active-low reset
//  start / stop        : one-cycle pulses from EN 0->1 / 1->0 register writes
//  reload              : CTRL.RELOAD level
//  done_clr            : W1C pulse for DONE (a coincident done_set wins)
//  load, prescale      : programmed LOAD / PRESCALE values
//  count, running, done: timer state; done_set pulses when the count expires
module delay_timer_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        reload,
   input  logic        done_clr,
   input  logic [31:0] load,
   input  logic [31:0] prescale,
   output logic [31:0] count,
   output logic        running,
   output logic        done,
   output logic        done_set
);

   logic [31:0] pre;
   logic [31:0] pre_lim;   // prescale snapshot; refreshed only at start and on wrap
   logic        wrap;

   assign wrap     = (pre == pre_lim);
   assign done_set = running & ~start & ~stop & wrap & (count == 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         pre     <= '0;
         pre_lim <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         if (done_set)      done <= 1'b1;
         else if (done_clr) done <= 1'b0;

         if (start) begin
            count   <= load;
            pre     <= '0;
            pre_lim <= prescale;
            running <= 1'b1;
         end else if (stop) begin
            running <= 1'b0;
         end else if (running) begin
            if (wrap) begin
               pre     <= '0;
               pre_lim <= prescale;
               if (count != 32'd0) count <= count - 32'd1;
               else if (reload)    count <= load;
               else                running <= 1'b0;
            end else begin
               pre <= pre + 32'd1;
            end
         end
      end
   end

endmodule

// File: rtl/delay_timer_axi_slave.sv
// rtl/delay_timer_axi_slave.sv - AXI4-Lite register file front end for the delay timer
//  s00_axi_aclk/aresetn : clock, asynchronous active-low reset
//  s00_axi_aw*/w*/b*    : write address/data/response channels (bresp always OKAY)
//  s00_axi_ar*/r*       : read address/data channels (rresp always OKAY)
//  irq                  : STATUS.DONE & CTRL.IRQ_EN
module delay_timer_axi_slave
   import delay_timer_pkg::*;
#(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 5
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_aresetn,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic                              irq
);

   wr_state_t   wr_state, wr_next;
   rd_state_t   rd_state, rd_next;

   logic [31:0] ctrl, load_reg, prescale_reg, scratch;
   logic [31:0] ctrl_next, rd_mux, rdata_q, count;
   logic        wr_fire, rd_fire, wr_ctrl;
   logic        start, stop, done_clr, running, done, done_set;
   logic [2:0]  wr_addr, rd_addr;
   logic        unused_bits;

   assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                          s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   assign wr_addr = s00_axi_awaddr[4:2];
   assign rd_addr = s00_axi_araddr[4:2];

   // Write channel: one ACCEPT cycle with both readies, then hold bvalid
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) wr_state <= WR_IDLE;
      else                  wr_state <= wr_next;
   end

   always_comb begin
      wr_next         = wr_state;
      s00_axi_awready = 1'b0;
      s00_axi_wready  = 1'b0;
      s00_axi_bvalid  = 1'b0;
      case (wr_state)
         WR_IDLE:   if (s00_axi_awvalid && s00_axi_wvalid) wr_next = WR_ACCEPT;
         WR_ACCEPT: begin
            s00_axi_awready = 1'b1;
            s00_axi_wready  = 1'b1;
            wr_next         = WR_RESP;
         end
         WR_RESP: begin
            s00_axi_bvalid = 1'b1;
            if (s00_axi_bready) wr_next = WR_IDLE;
         end
         default:   wr_next = WR_IDLE;
      endcase
   end

   // Read channel: one ACCEPT cycle with arready, then hold rvalid/rdata
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) rd_state <= RD_IDLE;
      else                  rd_state <= rd_next;
   end

   always_comb begin
      rd_next         = rd_state;
      s00_axi_arready = 1'b0;
      s00_axi_rvalid  = 1'b0;
      case (rd_state)
         RD_IDLE:   if (s00_axi_arvalid) rd_next = RD_ACCEPT;
         RD_ACCEPT: begin
            s00_axi_arready = 1'b1;
            rd_next         = RD_DATA;
         end
         RD_DATA: begin
            s00_axi_rvalid = 1'b1;
            if (s00_axi_rready) rd_next = RD_IDLE;
         end
         default:   rd_next = RD_IDLE;
      endcase
   end

   assign wr_fire       = (wr_state == WR_ACCEPT);
   assign rd_fire       = (rd_state == RD_ACCEPT);
   assign s00_axi_bresp = RESP_OKAY;
   assign s00_axi_rresp = RESP_OKAY;
   assign s00_axi_rdata = rdata_q;

   // EN edges are detected on the value about to be written, so a 1->1 rewrite is a no-op
   assign wr_ctrl   = wr_fire && (wr_addr == REG_CTRL);
   assign ctrl_next = apply_strb(ctrl, s00_axi_wdata, s00_axi_wstrb);
   assign start     = wr_ctrl &  ctrl_next[CTRL_EN] & ~ctrl[CTRL_EN];
   assign stop      = wr_ctrl & ~ctrl_next[CTRL_EN] &  ctrl[CTRL_EN];
   assign done_clr  = wr_fire && (wr_addr == REG_STATUS) &&
                      s00_axi_wstrb[0] && s00_axi_wdata[STATUS_DONE];

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         ctrl         <= '0;
         load_reg     <= '0;
         prescale_reg <= '0;
         scratch      <= '0;
      end else if (wr_fire) begin
         case (wr_addr)
            REG_CTRL:     ctrl         <= ctrl_next;
            REG_LOAD:     load_reg     <= apply_strb(load_reg, s00_axi_wdata, s00_axi_wstrb);
            REG_PRESCALE: prescale_reg <= apply_strb(prescale_reg, s00_axi_wdata, s00_axi_wstrb);
            REG_SCRATCH:  scratch      <= apply_strb(scratch, s00_axi_wdata, s00_axi_wstrb);
            default:      ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rd_addr)
         REG_CTRL:     rd_mux = ctrl;
         REG_LOAD:     rd_mux = load_reg;
         REG_PRESCALE: rd_mux = prescale_reg;
         REG_SCRATCH:  rd_mux = scratch;
         REG_STATUS: begin
            rd_mux[STATUS_DONE]    = done;
            rd_mux[STATUS_RUNNING] = running;
         end
         REG_COUNT:    rd_mux = count;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) rdata_q <= '0;
      else if (rd_fire)     rdata_q <= rd_mux;
   end

   delay_timer_core u_core (
      .clk      (s00_axi_aclk),
      .rst_n    (s00_axi_aresetn),
      .start    (start),
      .stop     (stop),
      .reload   (ctrl[CTRL_RELOAD]),
      .done_clr (done_clr),
      .load     (load_reg),
      .prescale (prescale_reg),
      .count    (count),
      .running  (running),
      .done     (done),
      .done_set (done_set)
   );

   assign irq = done & ctrl[CTRL_IRQ_EN];

endmodule
